// File: rtl/rpn_pkg.sv
// Shared types for the RPN stack sequencer: FSM states, status codes,
// ALU opcodes, error codes and the WAIT timeout limit.
package rpn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT      = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_ERROR     = 3'd4
    } state_e;

    localparam logic [2:0] STATUS_IDLE      = ST_IDLE;
    localparam logic [2:0] STATUS_ISSUE     = ST_ISSUE;
    localparam logic [2:0] STATUS_WAIT      = ST_WAIT;
    localparam logic [2:0] STATUS_WRITEBACK = ST_WRITEBACK;
    localparam logic [2:0] STATUS_ERROR     = ST_ERROR;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } opcode_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_OVF  = 2'd1,
        ERR_UNF  = 2'd2,
        ERR_TMO  = 2'd3
    } err_e;

    // Value of the WAIT counter during the 255th consecutive WAIT cycle.
    localparam logic [7:0] TMO_LAST = 8'd254;

endpackage

// File: rtl/rpn_stack_sequencer_if.sv
// Request, ALU and status signals of the RPN stack sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface rpn_stack_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    import rpn_pkg::*;

    logic                         push_i;
    logic [WIDTH-1:0]             data_i;
    logic                         op_i;
    opcode_e                      opcode_i;
    logic                         undo_i;
    logic [WIDTH-1:0]             alu_a_o;
    logic [WIDTH-1:0]             alu_b_o;
    opcode_e                      alu_op_o;
    logic                         alu_start_o;
    logic                         alu_done_i;
    logic [WIDTH-1:0]             alu_result_i;
    logic [WIDTH-1:0]             top_o;
    logic [$clog2(DEPTH+1)-1:0]   depth_o;
    logic                         busy_o;
    logic                         error_o;
    logic [2:0]                   status_o;
    err_e                         err_code_o;

    modport master (
        output push_i, data_i, op_i, opcode_i, undo_i, alu_done_i, alu_result_i,
        input  alu_a_o, alu_b_o, alu_op_o, alu_start_o, top_o, depth_o,
               busy_o, error_o, status_o, err_code_o
    );

    modport slave (
        input  push_i, data_i, op_i, opcode_i, undo_i, alu_done_i, alu_result_i,
        output alu_a_o, alu_b_o, alu_op_o, alu_start_o, top_o, depth_o,
               busy_o, error_o, status_o, err_code_o
    );

endinterface

// File: rtl/rpn_stack_regfile.sv
// Operand stack storage: DEPTH x WIDTH registers, one write port and two
// combinational read ports (top and second-from-top). Contents are not reset.
module rpn_stack_regfile #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    top_addr,
    input  logic [AW-1:0]    sec_addr,
    output logic [WIDTH-1:0] top_data,
    output logic [WIDTH-1:0] sec_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign top_data = mem[top_addr];
    assign sec_data = mem[sec_addr];

endmodule

// File: rtl/rpn_stack_sequencer.sv
// RPN operand stack with an external-ALU handshake sequencer.
// Define RPN_SEQ_TIMEOUT_EN to abort a WAIT that lasts 255 cycles (err TMO).
module rpn_stack_sequencer
    import rpn_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    rpn_stack_sequencer_if.slave bus
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    localparam logic [DW-1:0] FULL = DW'(DEPTH);
    localparam logic [DW-1:0] ONE  = DW'(1);
    localparam logic [DW-1:0] TWO  = DW'(2);

    localparam logic [2:0] IDLE      = STATUS_IDLE;
    localparam logic [2:0] ISSUE     = STATUS_ISSUE;
    localparam logic [2:0] WAIT      = STATUS_WAIT;
    localparam logic [2:0] WRITEBACK = STATUS_WRITEBACK;
    localparam logic [2:0] ERROR     = STATUS_ERROR;

    logic [2:0]       state;
    logic [DW-1:0]    depth;
    opcode_e          alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] result;
    err_e             err_code;

    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    sec_idx;
    logic [WIDTH-1:0] rd_top;
    logic [WIDTH-1:0] rd_sec;

    logic do_undo;
    logic do_op;
    logic do_push;
    logic timeout;

    // Undo beats op beats push; the losers of a same-cycle collision are dropped.
    assign do_undo = bus.undo_i;
    assign do_op   = bus.op_i && !bus.undo_i;
    assign do_push = bus.push_i && !bus.op_i && !bus.undo_i;

    assign top_idx = AW'(depth - ONE);
    assign sec_idx = AW'(depth - TWO);

    rpn_stack_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk      (clk),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .top_addr (top_idx),
        .sec_addr (sec_idx),
        .top_data (rd_top),
        .sec_data (rd_sec)
    );

    always_comb begin
        we    = 1'b0;
        waddr = AW'(depth);
        wdata = bus.data_i;
        if (state == IDLE && do_push && depth < FULL) begin
            we = 1'b1;
        end else if (state == WRITEBACK) begin
            we    = 1'b1;
            waddr = sec_idx;
            wdata = result;
        end
    end

`ifdef RPN_SEQ_TIMEOUT_EN
    logic [7:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (reset || state != WAIT) begin
            wait_cnt <= 8'd0;
        end else if (!bus.alu_done_i) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign timeout = (state == WAIT) && !bus.alu_done_i && (wait_cnt == TMO_LAST);
`else
    assign timeout = 1'b0;
`endif

    // Operands and opcode are captured on op acceptance so they hold steady
    // from ISSUE until WRITEBACK finishes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            depth    <= '0;
            alu_op   <= OP_ADD;
            alu_a    <= '0;
            alu_b    <= '0;
            result   <= '0;
            err_code <= ERR_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (do_undo) begin
                        if (depth != '0) begin
                            depth <= depth - ONE;
                        end
                    end else if (do_op) begin
                        if (depth >= TWO) begin
                            state  <= ISSUE;
                            alu_op <= bus.opcode_i;
                            alu_a  <= rd_sec;
                            alu_b  <= rd_top;
                        end else begin
                            state    <= ERROR;
                            err_code <= ERR_UNF;
                        end
                    end else if (do_push) begin
                        if (depth < FULL) begin
                            depth <= depth + ONE;
                        end else begin
                            state    <= ERROR;
                            err_code <= ERR_OVF;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.alu_done_i) begin
                        result <= bus.alu_result_i;
                        state  <= WRITEBACK;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.alu_done_i) begin
                        result <= bus.alu_result_i;
                        state  <= WRITEBACK;
                    end else if (timeout) begin
                        state    <= ERROR;
                        err_code <= ERR_TMO;
                    end
                end
                WRITEBACK: begin
                    depth <= depth - ONE;
                    state <= IDLE;
                end
                ERROR: begin
                    if (bus.undo_i) begin
                        state    <= IDLE;
                        err_code <= ERR_NONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.alu_a_o     = alu_a;
    assign bus.alu_b_o     = alu_b;
    assign bus.alu_op_o    = alu_op;
    assign bus.alu_start_o = (state == ISSUE);
    assign bus.top_o       = (depth == '0) ? '0 : rd_top;
    assign bus.depth_o     = depth;
    assign bus.busy_o      = (state != IDLE) && (state != ERROR);
    assign bus.error_o     = (state == ERROR);
    assign bus.status_o    = state;
    assign bus.err_code_o  = err_code;

endmodule
